// File: rtl/mod_sub_pipe.sv
// mod_sub_pipe: registered modular subtractor, (iData0 - iData1) mod iQ.
// Two-stage valid/ready pipeline with backpressure, one result per cycle.
// Stage 1 registers the raw difference (with borrow) and the modulus.
// Stage 2 applies the single add-back of q and registers the result.
// Optional macro MOD_SUB_PIPE_RANGE_CHK_EN adds oErr, flagging operands
// that violate the operand < q, q >= 1 preconditions.
module mod_sub_pipe #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData0,
  input  logic [BITWIDTH-1:0] iData1,
  input  logic [BITWIDTH-1:0] iQ,
  output logic                oValid,
  input  logic                iReady,
`ifdef MOD_SUB_PIPE_RANGE_CHK_EN
  output logic                oErr,
`endif
  output logic [BITWIDTH-1:0] oData
);

  logic                s1_valid;
  logic                s2_valid;
  logic [BITWIDTH:0]   s1_diff;
  logic [BITWIDTH-1:0] s1_q;
  logic [BITWIDTH-1:0] s2_result;
  logic                s2_free;
  logic                s1_adv;
  logic                accept;

  // Handshake: stage 2 frees on drain, stage 1 moves when stage 2 is free.
  // oReady is combinational from iReady so a full pipe can still stream.
  assign s2_free = ~s2_valid | iReady;
  assign s1_adv  = s1_valid & s2_free;
  assign oReady  = iRstN & ~iClr & (~s1_valid | s2_free);
  assign accept  = iValid & oReady;
  assign oValid  = s2_valid;

  // Correction: a borrow means the raw difference wrapped, add q back once.
  always_comb begin
    s2_result = s1_diff[BITWIDTH-1:0];
    if (s1_diff[BITWIDTH]) begin
      s2_result = s1_diff[BITWIDTH-1:0] + s1_q;
    end
  end

  // Pipeline valid flags; clear wins over every handshake event.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (iClr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid <= 1'b1;
      end else if (iReady) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Stage 1 data: difference with borrow bit plus the modulus sampled with it.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_diff <= '0;
      s1_q    <= '0;
    end else if (accept) begin
      s1_diff <= {1'b0, iData0} - {1'b0, iData1};
      s1_q    <= iQ;
    end
  end

  // Stage 2 data: oData only moves when stage 1 hands over a new value.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oData <= '0;
    end else if (!iClr && s1_adv) begin
      oData <= s2_result;
    end
  end

`ifdef MOD_SUB_PIPE_RANGE_CHK_EN
  logic s1_err;

  // Range flag travels alongside the data through both stages.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_err <= 1'b0;
      oErr   <= 1'b0;
    end else begin
      if (accept) begin
        s1_err <= (iData0 >= iQ) | (iData1 >= iQ) | (iQ == '0);
      end
      if (!iClr && s1_adv) begin
        oErr <= s1_err;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// tb_mod_sub_pipe: scoreboard bench for mod_sub_pipe.
// The driver pushes the reference result when an operand is accepted; the
// monitor pops and compares whenever the DUT presents a result.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module tb_mod_sub_pipe;
  localparam int W = `BITWIDTH;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  logic         iClk;
  logic         iRstN;
  logic         iClr;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] iData0;
  logic [W-1:0] iData1;
  logic [W-1:0] iQ;
  logic         oValid;
  logic         iReady;
  logic [W-1:0] oData;
`ifdef MOD_SUB_PIPE_RANGE_CHK_EN
  logic         oErr;
`endif

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;
  int   cyc   = 0;

  mod_sub_pipe #(.BITWIDTH(W)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iValid(iValid), .oReady(oReady),
    .iData0(iData0), .iData1(iData1), .iQ(iQ), .oValid(oValid), .iReady(iReady),
`ifdef MOD_SUB_PIPE_RANGE_CHK_EN
    .oErr(oErr),
`endif
    .oData(oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  // Reference: true modular difference when preconditions hold, otherwise
  // the raw difference with at most one add of q, wrapped to W bits.
  function automatic exp_t model(input longint unsigned a, b, q);
    exp_t r;
    longint unsigned m = longint'(1) << W;
    if (q != 0 && a < q && b < q) begin
      r.d = W'((a + q - b) % q);
      r.e = 1'b0;
    end else begin
      r.d = (a >= b) ? W'((a - b) % m) : W'((a + m + q - b) % m);
      r.e = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Present one operand and hold it until accepted; rr randomises iReady.
  task automatic send(input int unsigned a, b, q, input bit rr);
    bit done = 1'b0;
    iValid = 1'b1;
    iData0 = a[W-1:0];
    iData1 = b[W-1:0];
    iQ     = q[W-1:0];
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge iClk);
      if (oReady) begin
        sb.push_back(model(a, b, q));
        done = 1'b1;
      end
      @(posedge iClk);
      #1;
      if (rr) iReady = ($urandom_range(0, 3) != 0);
    end
    iValid = 1'b0;
    check("send_accept", done, 1);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk);
      #1;
      if (rr) iReady = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    iReady = 1'b1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      @(posedge iClk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compare the head of the scoreboard whenever a result is shown;
  // while stalled the held value must keep matching the same entry.
  always @(negedge iClk) begin
    if (iRstN && oValid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got %0d expected no result", oData);
      end else begin
        if (oData !== sb[0].d) begin
          fails++;
          $display("FAIL result_data: got %0d expected %0d (t=%0t)", oData, sb[0].d, $time);
        end
`ifdef MOD_SUB_PIPE_RANGE_CHK_EN
        tests++;
        if (oErr !== sb[0].e) begin
          fails++;
          $display("FAIL result_err: got %0d expected %0d (t=%0t)", oErr, sb[0].e, $time);
        end
`endif
        if (iReady) begin
          void'(sb.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int p0;
    longint unsigned qmax;
    qmax = (longint'(1) << W) - 1;
    iRstN = 1'b0; iClr = 1'b0; iValid = 1'b0; iReady = 1'b1;
    iData0 = '0; iData1 = '0; iQ = '0;

    // Reset state
    #25;
    check("reset_ovalid", oValid, 0);
    check("reset_odata", oData, 0);
    check("reset_oready", oReady, 0);
    @(posedge iClk); #1;
    iRstN = 1'b1;
    idle(2, 1'b0);

    // First result two edges after presentation: 10-20 mod 23 = 13
    send(10, 20, 23, 1'b0);
    check("lat_early_ovalid", oValid, 0);
    @(posedge iClk); #1;
    check("lat_ovalid", oValid, 1);
    check("lat_odata", oData, 13);
    drain();

    // Back-to-back stream, q = 23..32, 20-10 = 10 each
    c0 = cyc;
    p0 = pops;
    for (int q = 23; q <= 32; q++) send(20, 10, q, 1'b0);
    check("stream_cycles", cyc - c0, 10);
    @(negedge iClk); #1;
    check("stream_no_gaps", pops - p0, 9);
    drain();

    // Boundaries
    send(0, 0, 1, 1'b0);
    send(int'(qmax - 1), 0, int'(qmax), 1'b0);
    send(0, int'(qmax - 1), int'(qmax), 1'b0);
    drain();

    // Backpressure: three operands with the sink stalled
    iReady = 1'b0;
    send(3, 9, 17, 1'b0);
    send(16, 2, 17, 1'b0);
    iValid = 1'b1; iData0 = W'(5); iData1 = W'(6); iQ = W'(17);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check("bp_oready_low", oReady, 0);
      @(posedge iClk); #1;
    end
    iReady = 1'b1;
    send(5, 6, 17, 1'b0);
    drain();

    // Clear with both stages full
    iReady = 1'b0;
    send(7, 1, 11, 1'b0);
    send(8, 2, 11, 1'b0);
    iClr = 1'b1;
    @(negedge iClk);
    check("clr_oready", oReady, 0);
    @(posedge iClk); #1;
    iClr = 1'b0;
    check("clr_ovalid", oValid, 0);
    sb.delete();
    iReady = 1'b1;
    send(5, 7, 11, 1'b0);
    drain();

    // Precondition violation keeps the single add-back formula
    send(1, 200, 100, 1'b0);
    drain();

`ifdef MOD_SUB_PIPE_RANGE_CHK_EN
    send(30, 1, 23, 1'b0);
    drain();
`endif

    // Randomised traffic with random sink stalls
    for (int n = 0; n < 60; n++) begin
      int unsigned q, a, b;
      q = $urandom_range(1, int'(qmax));
      a = $urandom_range(0, q - 1);
      b = $urandom_range(0, q - 1);
      send(a, b, q, 1'b1);
      idle($urandom_range(0, 2), 1'b1);
    end
    drain();

    // Asynchronous reset mid-stream
    send(4, 1, 9, 1'b0);
    send(6, 8, 9, 1'b0);
    send(2, 2, 9, 1'b0);
    check("pre_rst_ovalid", oValid, 1);
    #1;
    iRstN = 1'b0;
    #1;
    check("rst_async_ovalid", oValid, 0);
    check("rst_async_odata", oData, 0);
    check("rst_async_oready", oReady, 0);
    sb.delete();
    @(posedge iClk); #1;
    iRstN = 1'b1;
    idle(1, 1'b0);
    send(12, 5, 13, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
